// File: rtl/frame_sched_pkg.sv
// Shared definitions for the bounce / frame scheduler / circle slice.
package frame_sched_pkg;

  // Coordinate bus width shared by bounce, frame_sched and circle.
  localparam int unsigned COORD_W = 11;

  // Default centre after reset (middle of a 640x480 screen).
  localparam int unsigned X_INIT = 320;
  localparam int unsigned Y_INIT = 240;

  // Frame scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStep  = 2'd1,
    StLatch = 2'd2,
    StHold  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_sched_sync_edge.sv
// Registered edge detector: start_o pulses when sig_i enters its active level.
module sync_edge #(
  parameter bit ActiveLevel = 1'b0,
  parameter bit ResetLevel  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic start_o
);

  logic sig_q;

  // Previous-cycle copy of the input; resetting to the active level suppresses
  // a spurious edge when the input is already active as reset releases.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= ResetLevel;
    end else begin
      sig_q <= sig_i;
    end
  end

  // Edge is the current level active while the previous level was not.
  always_comb begin
    start_o = (sig_i == ActiveLevel) && (sig_q != ActiveLevel);
  end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: paces bounce steps off VSYNC and double-buffers the centre
// so the circle renderer only sees a new position at a frame boundary.
module frame_sched #(
  parameter int unsigned COORD_W   = frame_sched_pkg::COORD_W,
  parameter int unsigned X_INIT    = frame_sched_pkg::X_INIT,
  parameter int unsigned Y_INIT    = frame_sched_pkg::Y_INIT,
  parameter bit          VS_ACTIVE = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               VSYNC,
  input  logic               pause,
  input  logic               single_step,
  input  logic [1:0]         speed,
  input  logic [COORD_W-1:0] next_x,
  input  logic [COORD_W-1:0] next_y,
  output logic               step,
  output logic [COORD_W-1:0] disp_x,
  output logic [COORD_W-1:0] disp_y,
  output logic [15:0]        frame_cnt
);

  import frame_sched_pkg::*;

  state_e             state_q, state_d;
  logic               step_q, step_d;
  logic [1:0]         div_cnt_q, div_cnt_d;
  logic               ss_pend_q, ss_pend_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [COORD_W-1:0] disp_x_q, disp_x_d;
  logic [COORD_W-1:0] disp_y_q, disp_y_d;
  logic               frame_start;
  logic               ss_req;

  sync_edge #(
    .ActiveLevel (VS_ACTIVE),
    .ResetLevel  (VS_ACTIVE)
  ) u_sync_edge (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .sig_i   (VSYNC),
    .start_o (frame_start)
  );

  // A single-step request only counts while paused.
  assign ss_req = single_step & pause;

  // Next-state logic: step decision at frame start, latch centre once per frame.
  always_comb begin
    state_d     = state_q;
    step_d      = 1'b0;
    div_cnt_d   = div_cnt_q;
    ss_pend_d   = ss_pend_q | ss_req;
    frame_cnt_d = frame_cnt_q;
    disp_x_d    = disp_x_q;
    disp_y_d    = disp_y_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StStep;
          if (pause) begin
            // A pulse coinciding with the frame start is honoured this frame.
            step_d    = ss_pend_q | ss_req;
            ss_pend_d = 1'b0;
          end else if (div_cnt_q >= speed) begin
            // >= so a speed lowered mid-count fires on the next frame.
            step_d    = 1'b1;
            div_cnt_d = 2'd0;
          end else begin
            div_cnt_d = div_cnt_q + 2'd1;
          end
        end
      end
      StStep: begin
        state_d = StLatch;
      end
      StLatch: begin
        // bounce has updated next_* at the end of the STEP cycle.
        disp_x_d = next_x;
        disp_y_d = next_y;
        state_d  = StHold;
      end
      StHold: begin
        if (VSYNC != VS_ACTIVE) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any step in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      step_q      <= 1'b0;
      div_cnt_q   <= 2'd0;
      ss_pend_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      disp_x_q    <= COORD_W'(X_INIT);
      disp_y_q    <= COORD_W'(Y_INIT);
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      div_cnt_q   <= div_cnt_d;
      ss_pend_q   <= ss_pend_d;
      frame_cnt_q <= frame_cnt_d;
      disp_x_q    <= disp_x_d;
      disp_y_q    <= disp_y_d;
    end
  end

  assign step      = step_q;
  assign disp_x    = disp_x_q;
  assign disp_y    = disp_y_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: step pacing, pause/single-step, centre latch.
module tb_frame_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VSYNC;
  logic        pause;
  logic        single_step;
  logic [1:0]  speed;
  logic [10:0] next_x;
  logic [10:0] next_y;
  logic        step;
  logic [10:0] disp_x;
  logic [10:0] disp_y;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int step_count = 0;
  int base;

  frame_sched #(
    .COORD_W   (11),
    .X_INIT    (320),
    .Y_INIT    (240),
    .VS_ACTIVE (1'b0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VSYNC       (VSYNC),
    .pause       (pause),
    .single_step (single_step),
    .speed       (speed),
    .next_x      (next_x),
    .next_y      (next_y),
    .step        (step),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .frame_cnt   (frame_cnt)
  );

  always #5 CLK = ~CLK;

  // Count every cycle in which step is high.
  always @(posedge CLK) begin
    if (step) step_count <= step_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One frame: 3-cycle active-low sync, then 5 inactive cycles.
  task automatic run_frame(input int nx, input int ny);
    next_x = 11'(nx);
    next_y = 11'(ny);
    VSYNC  = 1'b0;
    repeat (3) tick();
    VSYNC = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    RESET       = 1'b1;
    VSYNC       = 1'b0;
    pause       = 1'b0;
    single_step = 1'b0;
    speed       = 2'd0;
    next_x      = 11'd0;
    next_y      = 11'd0;
    repeat (3) tick();
    check("rst_step", {31'd0, step}, 0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    check("rst_disp_x", {21'd0, disp_x}, 320);
    check("rst_disp_y", {21'd0, disp_y}, 240);

    // Release reset with VSYNC already active: no frame start.
    RESET = 1'b0;
    base  = step_count;
    repeat (5) tick();
    check("vs_held_steps", step_count - base, 0);
    check("vs_held_frame_cnt", {16'd0, frame_cnt}, 0);
    check("vs_held_disp_x", {21'd0, disp_x}, 320);
    VSYNC = 1'b1;
    repeat (4) tick();
    check("vs_release_frame_cnt", {16'd0, frame_cnt}, 0);

    // speed=0, single frame with exact latency checks.
    next_x = 11'd100;
    next_y = 11'd50;
    base   = step_count;
    VSYNC  = 1'b0;
    tick();
    check("t1_step", {31'd0, step}, 1);
    check("t1_frame_cnt", {16'd0, frame_cnt}, 1);
    tick();
    check("t2_step", {31'd0, step}, 0);
    check("t2_disp_x_old", {21'd0, disp_x}, 320);
    tick();
    check("t3_disp_x", {21'd0, disp_x}, 100);
    check("t3_disp_y", {21'd0, disp_y}, 50);
    VSYNC = 1'b1;
    repeat (5) tick();
    check("t_frame_steps", step_count - base, 1);

    // speed=2: step on frames 3 and 6.
    speed = 2'd2;
    for (int i = 0; i < 6; i++) begin
      base = step_count;
      run_frame(200 + i, 300 - i);
      check($sformatf("spd2_f%0d_steps", i + 1), step_count - base, (i % 3 == 2) ? 1 : 0);
      check($sformatf("spd2_f%0d_cnt", i + 1), {16'd0, frame_cnt}, 2 + i);
      check($sformatf("spd2_f%0d_disp_x", i + 1), {21'd0, disp_x}, 200 + i);
    end
    base = step_count;
    run_frame(1, 2);
    check("spd2_div1_steps", step_count - base, 0);
    speed = 2'd0;
    base  = step_count;
    run_frame(3, 4);
    check("spd_drop_steps", step_count - base, 1);
    check("spd_drop_cnt", {16'd0, frame_cnt}, 9);

    // Paused for 4 frames, two single_step pulses during frame 2.
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base = step_count;
      run_frame(10 + i, 20 + i);
      if (i == 1) begin
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        tick();
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        tick();
      end
      check($sformatf("pause_f%0d_steps", i + 1), step_count - base, (i == 2) ? 1 : 0);
      check($sformatf("pause_f%0d_disp_x", i + 1), {21'd0, disp_x}, 10 + i);
      check($sformatf("pause_f%0d_disp_y", i + 1), {21'd0, disp_y}, 20 + i);
    end
    check("pause_cnt", {16'd0, frame_cnt}, 13);

    // single_step coinciding with frame start while paused.
    base        = step_count;
    VSYNC       = 1'b0;
    single_step = 1'b1;
    tick();
    single_step = 1'b0;
    check("ss_same_step", {31'd0, step}, 1);
    repeat (2) tick();
    VSYNC = 1'b1;
    repeat (5) tick();
    check("ss_same_steps", step_count - base, 1);

    // single_step while not paused is ignored, even once paused again.
    pause       = 1'b0;
    single_step = 1'b1;
    tick();
    single_step = 1'b0;
    pause       = 1'b1;
    tick();
    base = step_count;
    run_frame(7, 8);
    check("ss_unpaused_steps", step_count - base, 0);
    check("ss_unpaused_cnt", {16'd0, frame_cnt}, 15);

    // Reset during the STEP cycle drops the step.
    pause = 1'b0;
    speed = 2'd0;
    next_x = 11'd500;
    next_y = 11'd400;
    VSYNC = 1'b0;
    tick();
    check("rs_step_before", {31'd0, step}, 1);
    RESET = 1'b1;
    tick();
    check("rs_step_after", {31'd0, step}, 0);
    check("rs_frame_cnt", {16'd0, frame_cnt}, 0);
    check("rs_disp_x", {21'd0, disp_x}, 320);
    check("rs_disp_y", {21'd0, disp_y}, 240);
    RESET = 1'b0;
    repeat (2) tick();
    VSYNC = 1'b1;
    repeat (3) tick();
    check("rs_disp_x_hold", {21'd0, disp_x}, 320);

    // frame_cnt wrap: preload the counter, then one frame.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    check("wrap_pre", {16'd0, frame_cnt}, 65535);
    base = step_count;
    run_frame(9, 9);
    check("wrap_cnt", {16'd0, frame_cnt}, 0);
    check("wrap_steps", step_count - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
